// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and opcode helpers for the load/store sequencer.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (consumed by lsu_mem_ctrl).
package lsu_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // funct3 encodings of the load/store size field
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] size_mask(input logic [2:0] op);
    case (op)
      F3_B, F3_BU: return 4'b0001;
      F3_H, F3_HU: return 4'b0011;
      F3_W:        return 4'b1111;
      default:     return 4'b0000;
    endcase
  endfunction

  // Unsigned variants exist only for loads.
  function automatic logic op_illegal(input logic [2:0] op, input logic write);
    case (op)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return write;
      default:          return 1'b1;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_load_align.sv
// Load lane select and sign/zero extension; hi_word carries the second word
// of a split access so bytes crossing the word boundary are merged first.
module lsu_load_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [31:0] data
);

  logic [31:0] raw;

  always_comb begin
    raw = 32'({hi_word, lo_word} >> {off, 3'b000});
    case (op)
      F3_B:    data = {{24{raw[7]}}, raw[7:0]};
      F3_H:    data = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   data = {24'h0, raw[7:0]};
      F3_HU:   data = {16'h0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between execute stage and a variable-latency data port.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two word accesses.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  lw_sw_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_write_ctrl,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output lsu_state_t  dbg_state
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and every transfer yields exactly one resp_valid pulse.
  lsu_state_t     state;
  logic [2:0]     op_q;
  logic [1:0]     off_q;
  logic           write_q;
  logic           split_q;
  logic [3:0]     be_hi_q;
  logic [31:0]    wd_hi_q;
  logic [31:0]    rdata_lo_q;
  logic [CW-1:0]  tcnt;

  logic [7:0]     be_full;
  logic [63:0]    wd_full;
  logic [31:0]    wd_lo;
  logic [31:0]    wd_hi;
  logic           illegal;
  logic           misal;
  logic           reject;
  logic           crosses;
  logic           timeout_hit;
  logic [31:0]    align_lo;
  logic [31:0]    align_hi;
  logic [31:0]    load_data;

  assign be_full = {4'b0000, size_mask(lw_sw_op)} << addr[1:0];
  assign wd_full = {32'h0, wdata} << {addr[1:0], 3'b000};
  assign wd_lo   = wd_full[31:0]  & lane_mask(be_full[3:0]);
  assign wd_hi   = wd_full[63:32] & lane_mask(be_full[7:4]);
  assign illegal = op_illegal(lw_sw_op, req_write);
  assign misal   = op_misaligned(lw_sw_op, addr[1:0]);

`ifdef LSU_MISALIGN_SPLIT_EN
  assign reject  = illegal;
  assign crosses = misal & (|be_full[7:4]);
`else
  assign reject  = illegal | misal;
  assign crosses = 1'b0;
`endif

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (int'(tcnt) + 1 >= TIMEOUT_CYCLES);

  // During the second half the first word is already latched in rdata_lo_q.
  assign align_lo = (state == ACC2) ? rdata_lo_q : mem_rdata;
  assign align_hi = (state == ACC2) ? mem_rdata  : 32'h0;

  lsu_load_align u_align (
    .op      (op_q),
    .off     (off_q),
    .lo_word (align_lo),
    .hi_word (align_hi),
    .data    (load_data)
  );

  assign stall     = req_valid && !req_ready;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'h0;
      misalign_err   <= 1'b0;
      bus_err        <= 1'b0;
      mem_req        <= 1'b0;
      mem_addr       <= 32'h0;
      mem_write_ctrl <= 4'h0;
      mem_wdata      <= 32'h0;
      op_q           <= F3_B;
      off_q          <= 2'b00;
      write_q        <= 1'b0;
      split_q        <= 1'b0;
      be_hi_q        <= 4'h0;
      wd_hi_q        <= 32'h0;
      rdata_lo_q     <= 32'h0;
      tcnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready      <= 1'b0;
            op_q           <= lw_sw_op;
            off_q          <= addr[1:0];
            write_q        <= req_write;
            split_q        <= crosses;
            mem_addr       <= {addr[31:2], 2'b00};
            mem_write_ctrl <= req_write ? be_full[3:0] : 4'h0;
            mem_wdata      <= req_write ? wd_lo : 32'h0;
            be_hi_q        <= req_write ? be_full[7:4] : 4'h0;
            wd_hi_q        <= req_write ? wd_hi : 32'h0;
            tcnt           <= '0;
            if (reject) begin
              state        <= RESP;
              resp_valid   <= 1'b1;
              misalign_err <= 1'b1;
              resp_rdata   <= 32'h0;
            end else begin
              state   <= ACC;
              mem_req <= 1'b1;
            end
          end
        end
        ACC, ACC2: begin
          if (mem_ack) begin
            if (state == ACC && split_q) begin
              // mem_req stays high; the port sees the next word immediately
              state          <= ACC2;
              rdata_lo_q     <= mem_rdata;
              mem_addr       <= mem_addr + 32'd4;
              mem_write_ctrl <= be_hi_q;
              mem_wdata      <= wd_hi_q;
              tcnt           <= '0;
            end else begin
              state      <= RESP;
              mem_req    <= 1'b0;
              resp_valid <= 1'b1;
              resp_rdata <= write_q ? 32'h0 : load_data;
            end
          end else if (timeout_hit) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            bus_err    <= 1'b1;
            resp_rdata <= 32'h0;
          end else if (TIMEOUT_CYCLES != 0) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RESP: begin
          state        <= IDLE;
          req_ready    <= 1'b1;
          resp_valid   <= 1'b0;
          misalign_err <= 1'b0;
          bus_err      <= 1'b0;
          resp_rdata   <= 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
